// File: rtl/bpu_pkg.sv
// Shared types, field ranges and BTB line helpers for the BPU update path.
package bpu_pkg;

    localparam int BHTBTB_INDEX_WIDTH = 9;
    localparam int BTB_SLOTS          = 4;
    localparam int BTB_TARGET_W       = 32;
    localparam int BTB_LINE_W         = 129;

    // PC field ranges: set index and counter/target slot within the set
    localparam int IDX_HI  = 12;
    localparam int IDX_LO  = 4;
    localparam int SLOT_HI = 3;
    localparam int SLOT_LO = 2;

    typedef struct packed {
        logic [BHTBTB_INDEX_WIDTH-1:0] index;
        logic [1:0]                    slot;
        logic                          taken;
        logic [BTB_TARGET_W-1:0]       target;
    } bpu_upd_t;

    // Line-valid bit at the top plus the 32-bit lane selected by slot.
    function automatic logic [BTB_LINE_W-1:0] btb_line_mask(input logic [1:0] slot);
        logic [BTB_LINE_W-1:0] m;
        m = '0;
        m[BTB_LINE_W-1] = 1'b1;
        m[int'(slot)*BTB_TARGET_W +: BTB_TARGET_W] = '1;
        return m;
    endfunction

    // Write data: line-valid bit set, target placed in its lane, rest zero.
    function automatic logic [BTB_LINE_W-1:0] btb_line_data(input logic [1:0] slot,
                                                            input logic [BTB_TARGET_W-1:0] target);
        logic [BTB_LINE_W-1:0] d;
        d = '0;
        d[BTB_LINE_W-1] = 1'b1;
        d[int'(slot)*BTB_TARGET_W +: BTB_TARGET_W] = target;
        return d;
    endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Generic synchronous FIFO; no read bypass, head is a direct array read.
module bpu_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   occupancy
);

    localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ_q;
    logic             push_ok;
    logic             pop_ok;

    // Full and empty come from the registered occupancy only
    assign full      = (occ_q == FULL_OCC);
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign dout      = mem[rd_ptr];

    // Storage array, written at the tail
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
                2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/bpu_update.sv
// Queues resolved branches and drains one per cycle into registered
// BHT counter updates and BTB masked writes, with a saturating PMU count.
module bpu_update
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [63:0]                   res_pc,
    input  logic                          res_taken,
    input  logic [63:0]                   res_target,
    input  logic                          drain_stall,
    output logic                          bht_write_enable,
    output logic [BHTBTB_INDEX_WIDTH-1:0] bht_write_index,
    output logic [1:0]                    bht_write_counter_select,
    output logic                          bht_write_inc,
    output logic                          bht_write_dec,
    output logic                          bht_valid_in,
    output logic                          btb_ce,
    output logic                          btb_we,
    output logic [BTB_LINE_W-1:0]         btb_wmask,
    output logic [BHTBTB_INDEX_WIDTH-1:0] btb_write_index,
    output logic [BTB_LINE_W-1:0]         btb_din,
    output logic [31:0]                   upd_count,
    output logic                          fifo_empty
);

    bpu_upd_t       rec_in;
    bpu_upd_t       head;
    logic           fifo_full;
    logic           fifo_is_empty;
    logic [PTR_W:0] fifo_occ;
    logic           push;
    logic           pop;
    logic [31:0]    count_q;
    logic           unused_bits;

    // Only the index/slot PC bits and the low target word are retained
    assign rec_in = '{index:  res_pc[IDX_HI:IDX_LO],
                      slot:   res_pc[SLOT_HI:SLOT_LO],
                      taken:  res_taken,
                      target: res_target[BTB_TARGET_W-1:0]};

    assign unused_bits = ^{res_pc[63:IDX_HI+1], res_pc[SLOT_LO-1:0],
                           res_target[63:BTB_TARGET_W], fifo_occ};

    assign res_ready  = !fifo_full;
    assign fifo_empty = fifo_is_empty;
    assign push       = res_valid && res_ready;
    assign pop        = !fifo_is_empty && !drain_stall;
    assign upd_count  = count_q;

    bpu_upd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(bpu_upd_t)),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .din       (rec_in),
        .pop       (pop),
        .dout      (head),
        .full      (fifo_full),
        .empty     (fifo_is_empty),
        .occupancy (fifo_occ)
    );

    // Register the write strobes for the popped head; indices and data hold when idle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bht_write_enable         <= 1'b0;
            bht_write_index          <= '0;
            bht_write_counter_select <= '0;
            bht_write_inc            <= 1'b0;
            bht_write_dec            <= 1'b0;
            bht_valid_in             <= 1'b0;
            btb_ce                   <= 1'b0;
            btb_we                   <= 1'b0;
            btb_wmask                <= '0;
            btb_write_index          <= '0;
            btb_din                  <= '0;
        end else begin
            bht_write_enable <= 1'b0;
            bht_write_inc    <= 1'b0;
            bht_write_dec    <= 1'b0;
            bht_valid_in     <= 1'b0;
            btb_ce           <= 1'b0;
            btb_we           <= 1'b0;
            btb_wmask        <= '0;
            if (pop) begin
                bht_write_enable         <= 1'b1;
                bht_write_index          <= head.index;
                bht_write_counter_select <= head.slot;
                bht_write_inc            <= head.taken;
                bht_write_dec            <= !head.taken;
                bht_valid_in             <= 1'b1;
                if (head.taken) begin
                    btb_ce          <= 1'b1;
                    btb_we          <= 1'b1;
                    btb_write_index <= head.index;
                    btb_wmask       <= btb_line_mask(head.slot);
                    btb_din         <= btb_line_data(head.slot, head.target);
                end
            end
        end
    end

    // PMU count of issued updates, sticks at all-ones
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (pop && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_bpu_update.sv
// Scoreboard bench for bpu_update: expected updates queued at push time,
// checked against the registered write interface as they appear.
module tb_bpu_update;

    typedef struct {
        logic [8:0]  idx;
        logic [1:0]  slot;
        logic        tk;
        logic [31:0] tgt;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [63:0]   res_pc = '0;
    logic          res_taken = 1'b0;
    logic [63:0]   res_target = '0;
    logic          drain_stall = 1'b0;
    logic          bht_write_enable;
    logic [8:0]    bht_write_index;
    logic [1:0]    bht_write_counter_select;
    logic          bht_write_inc;
    logic          bht_write_dec;
    logic          bht_valid_in;
    logic          btb_ce;
    logic          btb_we;
    logic [128:0]  btb_wmask;
    logic [8:0]    btb_write_index;
    logic [128:0]  btb_din;
    logic [31:0]   upd_count;
    logic          fifo_empty;

    exp_t          exp_q[$];
    exp_t          e;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   exp_count = '0;
    logic [128:0]  last_din = '0;
    logic [8:0]    last_bht_idx = '0;
    bit            mon_en = 1'b0;

    always #5 clock = ~clock;

    bpu_update #(.DEPTH(4), .PTR_W(2)) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .res_valid                (res_valid),
        .res_ready                (res_ready),
        .res_pc                   (res_pc),
        .res_taken                (res_taken),
        .res_target               (res_target),
        .drain_stall              (drain_stall),
        .bht_write_enable         (bht_write_enable),
        .bht_write_index          (bht_write_index),
        .bht_write_counter_select (bht_write_counter_select),
        .bht_write_inc            (bht_write_inc),
        .bht_write_dec            (bht_write_dec),
        .bht_valid_in             (bht_valid_in),
        .btb_ce                   (btb_ce),
        .btb_we                   (btb_we),
        .btb_wmask                (btb_wmask),
        .btb_write_index          (btb_write_index),
        .btb_din                  (btb_din),
        .upd_count                (upd_count),
        .fifo_empty               (fifo_empty)
    );

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bitwise construction of a BTB line: valid bit 128 plus one 32-bit lane
    function automatic logic [128:0] line_of(input logic [1:0] s, input logic [31:0] v);
        logic [128:0] r;
        r = '0;
        r[128] = 1'b1;
        for (int b = 0; b < 32; b++) r[32*s + b] = v[b];
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
        exp_t x;
        x.idx  = pc[12:4];
        x.slot = pc[3:2];
        x.tk   = tk;
        x.tgt  = tgt[31:0];
        return x;
    endfunction

    // Monitor: compare each cycle's registered outputs against the scoreboard
    always @(posedge clock) begin
        #1;
        if (mon_en) begin
            if (bht_write_enable) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bht_index", bht_write_index, e.idx);
                    chk("bht_select", bht_write_counter_select, e.slot);
                    chk("bht_inc", bht_write_inc, e.tk);
                    chk("bht_dec", bht_write_dec, !e.tk);
                    chk("bht_valid_in", bht_valid_in, 1);
                    chk("btb_ce", btb_ce, e.tk);
                    chk("btb_we", btb_we, e.tk);
                    last_bht_idx = e.idx;
                    if (e.tk) begin
                        chk("btb_index", btb_write_index, e.idx);
                        chk("btb_wmask", btb_wmask, line_of(e.slot, 32'hFFFF_FFFF));
                        chk("btb_din", btb_din, line_of(e.slot, e.tgt));
                        last_din = line_of(e.slot, e.tgt);
                    end else begin
                        chk("btb_wmask_nt", btb_wmask, 0);
                    end
                    if (exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 1;
                end
            end else begin
                chk("idle_strobes", {btb_ce, btb_we, bht_write_inc, bht_write_dec, bht_valid_in}, 0);
                chk("idle_wmask", btb_wmask, 0);
                chk("idle_din_hold", btb_din, last_din);
                chk("idle_idx_hold", bht_write_index, last_bht_idx);
            end
            chk("upd_count", upd_count, exp_count);
        end
    end

    // Called at a negedge; holds the record until accepted, returns at a negedge
    task automatic push_rec(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
        int n;
        n = 0;
        res_valid  = 1'b1;
        res_pc     = pc;
        res_taken  = tk;
        res_target = tgt;
        while (!res_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!res_ready) chk("push_timeout", 0, 1);
        else exp_q.push_back(mk_exp(pc, tk, tgt));
        @(negedge clock);
        res_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !fifo_empty) && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        exp_count = '0;
        last_din = '0;
        last_bht_idx = '0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        chk("rst_ready", res_ready, 1);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_count", upd_count, 0);
        chk("rst_strobes", {bht_write_enable, bht_write_inc, bht_write_dec, bht_valid_in, btb_ce, btb_we}, 0);
        chk("rst_wmask", btb_wmask, 0);
        chk("rst_din", btb_din, 0);
        chk("rst_idx", {bht_write_index, btb_write_index, bht_write_counter_select}, 0);
        mon_en = 1'b1;

        // 1: single taken update, visible two cycles after the push
        push_rec(64'h1238, 1'b1, 64'h8000_4000);
        @(posedge clock); #1;
        chk("t1_we", bht_write_enable, 1);
        chk("t1_din_lane", btb_din[95:64], 32'h8000_4000);
        chk("t1_mask", btb_wmask, {1'b1, 32'h0, 32'hFFFF_FFFF, 64'h0});
        chk("t1_count", upd_count, 1);
        @(negedge clock);
        wait_drain("t1_drain");

        // 2: not-taken update
        push_rec(64'h40, 1'b0, 64'h1234_5678);
        wait_drain("t2_drain");
        chk("t2_count", upd_count, 2);

        // 3: stall fills the FIFO, fifth record held until space frees
        drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_rec(64'h100 + 64'(i*4), i[0], 64'hA000_0000 + 64'(i));
        chk("t3_ready_full", res_ready, 0);
        chk("t3_not_empty", fifo_empty, 0);
        repeat (3) @(negedge clock);
        chk("t3_still_full", res_ready, 0);
        drain_stall = 1'b0;
        push_rec(64'h2FFC, 1'b1, 64'hDEAD_BEEF);
        wait_drain("t3_drain");
        chk("t3_count", upd_count, 7);

        // 4: steady push and pop at occupancy 2
        drain_stall = 1'b1;
        push_rec(64'h300, 1'b1, 64'h1111_0000);
        push_rec(64'h304, 1'b0, 64'h2222_0000);
        drain_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t4_occ", dut.u_fifo.occupancy, 2);
            res_valid  = 1'b1;
            res_pc     = 64'h400 + 64'(i*20);
            res_taken  = i[1];
            res_target = 64'hC000_0000 + 64'(i*3);
            exp_q.push_back(mk_exp(res_pc, res_taken, res_target));
            @(negedge clock);
        end
        res_valid = 1'b0;
        chk("t4_occ_end", dut.u_fifo.occupancy, 2);
        wait_drain("t4_drain");
        chk("t4_count", upd_count, 19);

        // 5: reset while draining discards the queue
        drain_stall = 1'b1;
        for (int i = 0; i < 3; i++) push_rec(64'h500 + 64'(i*4), 1'b1, 64'h5555_0000 + 64'(i));
        drain_stall = 1'b0;
        @(negedge clock);
        do_reset();
        chk("t5_empty", fifo_empty, 1);
        chk("t5_count", upd_count, 0);
        chk("t5_ready", res_ready, 1);
        chk("t5_we", bht_write_enable, 0);
        repeat (4) @(negedge clock);
        chk("t5_empty_later", fifo_empty, 1);

        // 6: counter saturation
        force dut.count_q = 32'hFFFF_FFFE;
        exp_count = 32'hFFFF_FFFE;
        @(negedge clock);
        release dut.count_q;
        for (int i = 0; i < 3; i++) push_rec(64'h600 + 64'(i*4), 1'b0, 64'h0);
        wait_drain("t6_drain");
        chk("t6_sat", upd_count, 32'hFFFF_FFFF);
        repeat (3) @(negedge clock);
        chk("t6_sat_hold", upd_count, 32'hFFFF_FFFF);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
